switch_conditioner: RTL and testbench
=====================================

# switch_conditioner

Input-conditioning stage directly upstream of the picoMIPS core. It synchronises the raw slide switches, debounces the strobe switch (SW8), and captures the 8-bit data switches on each clean press. It presents the core with a glitch-free strobe level, one-cycle press/release pulses and a held data byte with a valid/ack handshake. Reset is driven from SW9 by the top level.

## Interface
Parameters:
- DATA_WIDTH, 8, width of data switches and captured byte
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronised cycles required to accept a strobe edge (1 ms at 50 MHz); legal range >= 2
- Counter width is $clog2(DEBOUNCE_CYCLES).

Ports:
- clk  in  1  system clock (50 MHz)
- n_reset  in  1  asynchronous, active-low reset
- sw_data  in  DATA_WIDTH  raw data switches (SW[7:0]), asynchronous
- sw_strobe  in  1  raw strobe switch (SW8), asynchronous, bouncy
- strobe_level  out  1  debounced strobe level
- press  out  1  one-cycle pulse on accepted rising edge
- release  out  1  one-cycle pulse on accepted falling edge
- data_out  out  DATA_WIDTH  byte captured at last accepted press
- data_valid  out  1  data_out unconsumed
- data_ack  in  1  consumer acknowledges data_out
- overrun  out  1  sticky: press accepted while data_valid was still set

## Operation
- Synchronise sw_data and sw_strobe through two flops each; reset value 0. Downstream logic uses only synchronised copies (sdata, sstrobe).
- Debounce FSM states: LOW, RISE_WAIT, HIGH, FALL_WAIT; reset state LOW, counter 0.
  - LOW: sstrobe=1 -> RISE_WAIT, cnt<=0.
  - RISE_WAIT: sstrobe=0 -> LOW (bounce rejected, no pulse). sstrobe=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, press<=1, data_out<=sdata. Otherwise cnt++.
  - HIGH: sstrobe=0 -> FALL_WAIT, cnt<=0.
  - FALL_WAIT: sstrobe=1 -> HIGH (no pulse). sstrobe=0 and cnt==DEBOUNCE_CYCLES-1 -> LOW, release<=1. Otherwise cnt++.
- strobe_level = 1 in HIGH and FALL_WAIT, else 0 (registered, state-decoded).
- press/release are registered, high for exactly one cycle.
- Handshake: press sets data_valid. data_ack with data_valid=1 clears it. Press and ack in the same cycle: data_valid stays 1 (new byte wins).
- Press while data_valid=1 and no ack that cycle: data_out overwritten, overrun<=1. Overrun clears only on reset.
- data_ack while data_valid=0: ignored.
- data_out changes only on an accepted press. Data switch changes at any other time have no effect.

## Timing
- Reset values: strobe_level 0, press 0, release 0, data_out 0, data_valid 0, overrun 0. The async assert takes effect immediately, even mid-debounce, and an in-flight edge is discarded. Release is synchronous to clk through the normal flop path.
- Latency: number rising edges from the first edge that samples sw_strobe=1 as edge 1, with the input held steady. press, strobe_level and data_out update on edge DEBOUNCE_CYCLES+3. release has the same latency from the falling input.
- data_out equals sw_data as sampled at edge DEBOUNCE_CYCLES+1 (two-flop delay). sw_data must be stable for 3 cycles around that edge.
- Any bounce shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse and no level change.
- Counter never exceeds DEBOUNCE_CYCLES-1 and does not wrap.

## Structure
- Shared package (constants.sv): typedef for the debounce state enum; default DEBOUNCE_CYCLES constant; SWITCH_WIDTH / data width macros reused.
- Sub-module sync_2ff (parameterised width, async active-low reset), instantiated once for sw_data and once for sw_strobe.
- All remaining logic (FSM, counter, capture, handshake) lives in switch_conditioner.

## Test plan
Benches use DEBOUNCE_CYCLES=4.
- Reset: n_reset=0 with sw_strobe=1 and sw_data=8'hA5 -> all outputs 0 throughout. Release reset with inputs held -> press at edge 7 after release, data_out=8'hA5, data_valid=1.
- Clean press: sw_data=8'h7F, then sw_strobe 0->1 held -> press exactly one cycle at edge 7, strobe_level=1, data_out=8'h7F. Fall -> release at edge 7, strobe_level=0.
- Bounce: strobe high 3 cycles, low 1, high 3, low -> no press, strobe_level stays 0, data_valid stays 0.
- Handshake: press with 8'h05, then data_ack for one cycle -> data_valid=0 next cycle, data_out still 8'h05.
- Overrun: press with 8'hF4, no ack, second press with 8'h80 -> data_out=8'h80, overrun=1. Ack -> data_valid=0, overrun remains 1. Also drive ack coincident with press -> data_valid=1.
- Reset mid-debounce: assert n_reset during RISE_WAIT -> outputs 0 immediately. After release with strobe already high -> full debounce restarts, press at edge 7.

Source files
------------

// File: rtl/switch_conditioner_pkg.sv
// Shared types and defaults for the switch conditioning front end.
package switch_conditioner_pkg;

    localparam int unsigned SwitchWidth           = 8;
    localparam int unsigned DefaultDebounceCycles = 50000;

    typedef enum logic [1:0] {
        StLow,
        StRiseWait,
        StHigh,
        StFallWait
    } deb_state_e;

endpackage

// File: rtl/switch_conditioner_sync_2ff.sv
// Two-flop synchroniser for asynchronous switch inputs.
module switch_conditioner_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/switch_conditioner.sv
// Synchronises slide switches, debounces the strobe and captures the data byte
// on each accepted press, with a valid/ack handshake and sticky overrun flag.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = SwitchWidth,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [DATA_WIDTH-1:0] sw_data,
    input  logic                  sw_strobe,
    output logic                  strobe_level,
    output logic                  press,
    output logic                  release_pulse,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ack,
    output logic                  overrun
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [DATA_WIDTH-1:0] sdata;
    logic                  sstrobe;

    switch_conditioner_sync_2ff #(
        .WIDTH(DATA_WIDTH)
    ) u_sync_data (
        .clk    (clk),
        .n_reset(n_reset),
        .d      (sw_data),
        .q      (sdata)
    );

    switch_conditioner_sync_2ff #(
        .WIDTH(1)
    ) u_sync_strobe (
        .clk    (clk),
        .n_reset(n_reset),
        .d      (sw_strobe),
        .q      (sstrobe)
    );

    deb_state_e            state_d, state_q;
    logic [CntW-1:0]       cnt_d, cnt_q;
    logic                  press_d, press_q;
    logic                  release_d, release_q;
    logic                  strobe_level_d, strobe_level_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  valid_d, valid_q;
    logic                  overrun_d, overrun_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            StLow: begin
                if (sstrobe) begin
                    state_d = StRiseWait;
                    cnt_d   = '0;
                end
            end
            StRiseWait: begin
                if (!sstrobe) begin
                    state_d = StLow;
                end else if (cnt_q == CntMax) begin
                    state_d = StHigh;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHigh: begin
                if (!sstrobe) begin
                    state_d = StFallWait;
                    cnt_d   = '0;
                end
            end
            StFallWait: begin
                if (sstrobe) begin
                    state_d = StHigh;
                end else if (cnt_q == CntMax) begin
                    state_d   = StLow;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StLow;
        endcase

        strobe_level_d = (state_d == StHigh) || (state_d == StFallWait);

        // A new press always wins over a coincident ack.
        data_d    = press_d ? sdata : data_q;
        valid_d   = valid_q;
        if (press_d) begin
            valid_d = 1'b1;
        end else if (data_ack && valid_q) begin
            valid_d = 1'b0;
        end
        overrun_d = overrun_q | (press_d & valid_q & ~data_ack);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q        <= StLow;
            cnt_q          <= '0;
            press_q        <= 1'b0;
            release_q      <= 1'b0;
            strobe_level_q <= 1'b0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            press_q        <= press_d;
            release_q      <= release_d;
            strobe_level_q <= strobe_level_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign strobe_level  = strobe_level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with a short debounce window.
module tb_switch_conditioner;

    localparam int unsigned DW = 8;
    localparam int unsigned DC = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    logic [DW-1:0] sw_data;
    logic          sw_strobe;
    logic          strobe_level;
    logic          press;
    logic          release_pulse;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ack;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;

    switch_conditioner #(
        .DATA_WIDTH     (DW),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .sw_data      (sw_data),
        .sw_strobe    (sw_strobe),
        .strobe_level (strobe_level),
        .press        (press),
        .release_pulse(release_pulse),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ack     (data_ack),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " level"}, strobe_level, 0);
        check({tag, " press"}, press, 0);
        check({tag, " release"}, release_pulse, 0);
        check({tag, " data"}, data_out, 0);
        check({tag, " valid"}, data_valid, 0);
        check({tag, " overrun"}, overrun, 0);
    endtask

    // Strobe rises just after a negedge; press is visible after the 7th edge.
    task automatic do_press(input logic [7:0] d, input string tag);
        sw_data   = d;
        sw_strobe = 1'b1;
        wait_neg(DC + 2);
        check({tag, " no early press"}, press, 0);
        wait_neg(1);
        check({tag, " press"}, press, 1);
        check({tag, " level"}, strobe_level, 1);
        check({tag, " data"}, data_out, d);
        wait_neg(1);
        check({tag, " press one cycle"}, press, 0);
    endtask

    task automatic do_release(input string tag);
        sw_strobe = 1'b0;
        wait_neg(DC + 2);
        check({tag, " no early release"}, release_pulse, 0);
        check({tag, " level held"}, strobe_level, 1);
        wait_neg(1);
        check({tag, " release"}, release_pulse, 1);
        check({tag, " level low"}, strobe_level, 0);
        wait_neg(1);
        check({tag, " release one cycle"}, release_pulse, 0);
    endtask

    task automatic do_ack(input string tag);
        data_ack = 1'b1;
        wait_neg(1);
        data_ack = 1'b0;
        check({tag, " valid cleared"}, data_valid, 0);
    endtask

    initial begin
        logic seen;
        n_reset   = 1'b0;
        sw_strobe = 1'b1;
        sw_data   = 8'hA5;
        data_ack  = 1'b0;

        // Reset held with active inputs
        #1;
        check_idle_outputs("rst0");
        wait_neg(4);
        check_idle_outputs("rst");
        n_reset = 1'b1;
        do_press(8'hA5, "post-rst");
        check("post-rst valid", data_valid, 1);
        do_ack("post-rst");
        check("post-rst data kept", data_out, 8'hA5);
        do_release("rel1");

        // Clean press / release
        do_press(8'h7F, "clean");
        check("clean valid", data_valid, 1);
        do_ack("clean");
        do_release("clean");

        // Bounce: 3 high, 1 low, 3 high, low; data changes must be ignored
        seen = 1'b0;
        sw_data   = 8'h33;
        sw_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin wait_neg(1); seen |= press | strobe_level; end
        sw_strobe = 1'b0;
        wait_neg(1); seen |= press | strobe_level;
        sw_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin wait_neg(1); seen |= press | strobe_level; end
        sw_strobe = 1'b0;
        for (int i = 0; i < 12; i++) begin wait_neg(1); seen |= press | strobe_level; end
        check("bounce no press/level", seen, 0);
        check("bounce valid", data_valid, 0);
        check("bounce data", data_out, 8'h7F);

        // Handshake
        do_press(8'h05, "hs");
        check("hs valid", data_valid, 1);
        do_ack("hs");
        check("hs data kept", data_out, 8'h05);
        data_ack = 1'b1;
        wait_neg(1);
        data_ack = 1'b0;
        check("hs ack while idle", data_valid, 0);
        check("hs no overrun", overrun, 0);
        do_release("hs");

        // Overrun
        do_press(8'hF4, "ovr1");
        do_release("ovr1");
        check("ovr1 no overrun yet", overrun, 0);
        do_press(8'h80, "ovr2");
        check("ovr2 overrun", overrun, 1);
        check("ovr2 valid", data_valid, 1);
        do_ack("ovr2");
        check("ovr2 overrun sticky", overrun, 1);
        do_release("ovr2");

        // Press on the same edge as ack, with a byte already pending
        do_press(8'h21, "pend");
        do_release("pend");
        check("pend valid", data_valid, 1);
        sw_data   = 8'h11;
        sw_strobe = 1'b1;
        wait_neg(DC + 2);
        data_ack = 1'b1;
        wait_neg(1);
        data_ack = 1'b0;
        check("coinc press", press, 1);
        check("coinc valid", data_valid, 1);
        check("coinc data", data_out, 8'h11);
        do_release("coinc");

        // Reset asserted mid-debounce
        sw_data   = 8'h3C;
        sw_strobe = 1'b1;
        wait_neg(4);
        n_reset = 1'b0;
        #1;
        check_idle_outputs("midrst");
        wait_neg(1);
        n_reset = 1'b1;
        do_press(8'h3C, "midrst");
        check("midrst valid", data_valid, 1);
        check("midrst overrun", overrun, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
